vx_operands_split: RTL and testbench

Parametrised operand lane-batcher between operand collection and the execute units. It accepts one full-warp operand packet per handshake (NUM_THREADS lanes of rs1/rs2/rs3 plus opaque metadata) into a DEPTH-entry elastic buffer. It replays each packet as NUM_THREADS/NUM_LANES narrower beats of NUM_LANES lanes and, optionally, skips beats whose thread mask is all zero. It carries batch index and start/end-of-packet markers so narrow execute units can run full warps.

---
 rtl/vx_operands_split.sv | 168 ++++++++++++++++
 tb/tb_vx_operands_split.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_operands_split.sv
// Operand lane-batcher: buffers full-warp operand packets and replays each one
// as NUM_LANES-wide beats, optionally skipping beats whose thread mask is empty.
module vx_operands_split #(
   parameter  int NUM_THREADS = 4,
   parameter  int NUM_LANES   = 2,
   parameter  int XLEN        = 32,
   parameter  int META_W      = 64,
   parameter  int DEPTH       = 2,
   parameter  int SKIP_EMPTY  = 1,
   localparam int BATCHES     = NUM_THREADS / NUM_LANES,
   localparam int PID_W       = (BATCHES > 1) ? $clog2(BATCHES) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [META_W-1:0]           in_meta,
   input  logic [NUM_THREADS-1:0]      in_tmask,
   input  logic [NUM_THREADS*XLEN-1:0] in_rs1,
   input  logic [NUM_THREADS*XLEN-1:0] in_rs2,
   input  logic [NUM_THREADS*XLEN-1:0] in_rs3,
   output logic                        in_ready,
   output logic                        out_valid,
   output logic [META_W-1:0]           out_meta,
   output logic [NUM_LANES-1:0]        out_tmask,
   output logic [NUM_LANES*XLEN-1:0]   out_rs1,
   output logic [NUM_LANES*XLEN-1:0]   out_rs2,
   output logic [NUM_LANES*XLEN-1:0]   out_rs3,
   output logic [PID_W-1:0]            out_pid,
   output logic                        out_sop,
   output logic                        out_eop,
   input  logic                        out_ready,
   output logic                        busy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int LW    = NUM_LANES * XLEN;
   localparam int PW    = NUM_THREADS * XLEN;

   logic [META_W-1:0]      meta_mem_q  [DEPTH];
   logic [NUM_THREADS-1:0] tmask_mem_q [DEPTH];
   logic [PW-1:0]          rs1_mem_q   [DEPTH];
   logic [PW-1:0]          rs2_mem_q   [DEPTH];
   logic [PW-1:0]          rs3_mem_q   [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PID_W-1:0] cur_pid_q, cur_pid_d;

   logic [NUM_THREADS-1:0] head_tmask_s;
   logic [PW-1:0]          head_rs1_s, head_rs2_s, head_rs3_s;
   logic [BATCHES-1:0]     chunk_s;
   logic [PID_W-1:0]       first_s, next_s, beat_pid_s;
   logic                   last_s;
   logic                   push_s, beat_fire_s, pop_s;

   assign head_tmask_s = tmask_mem_q[rd_ptr_q];
   assign head_rs1_s   = rs1_mem_q[rd_ptr_q];
   assign head_rs2_s   = rs2_mem_q[rd_ptr_q];
   assign head_rs3_s   = rs3_mem_q[rd_ptr_q];

   for (genvar g = 0; g < BATCHES; g++) begin : g_chunk
      assign chunk_s[g] = |head_tmask_s[g*NUM_LANES +: NUM_LANES];
   end

   // Beat walker: first live chunk, the one after the current beat, and the end marker.
   always_comb begin
      first_s    = '0;
      next_s     = '0;
      last_s     = 1'b1;
      beat_pid_s = '0;
      if (SKIP_EMPTY != 0) begin
         // Downward scans so the lowest matching chunk is the one that sticks.
         for (int k = BATCHES - 1; k >= 0; k--) begin
            if (chunk_s[k]) begin
               first_s = PID_W'(k);
            end else begin
               first_s = first_s;
            end
         end
         beat_pid_s = (cur_pid_q == '0) ? first_s : cur_pid_q;
         for (int k = BATCHES - 1; k >= 0; k--) begin
            if (chunk_s[k] && (PID_W'(k) > beat_pid_s)) begin
               next_s = PID_W'(k);
               last_s = 1'b0;
            end else begin
               next_s = next_s;
            end
         end
      end else begin
         beat_pid_s = cur_pid_q;
         next_s     = cur_pid_q + PID_W'(1);
         last_s     = (cur_pid_q == PID_W'(BATCHES - 1));
      end
   end

   assign out_valid   = !reset && (count_q != '0);
   assign busy        = out_valid;
   assign in_ready    = !reset && (count_q != CNT_W'(DEPTH));
   assign out_meta    = meta_mem_q[rd_ptr_q];
   assign out_tmask   = head_tmask_s[int'(beat_pid_s)*NUM_LANES +: NUM_LANES];
   assign out_rs1     = head_rs1_s[int'(beat_pid_s)*LW +: LW];
   assign out_rs2     = head_rs2_s[int'(beat_pid_s)*LW +: LW];
   assign out_rs3     = head_rs3_s[int'(beat_pid_s)*LW +: LW];
   assign out_pid     = out_valid ? beat_pid_s : '0;
   assign out_sop     = out_valid && (beat_pid_s == first_s);
   assign out_eop     = out_valid && last_s;

   assign push_s      = in_valid && in_ready;
   assign beat_fire_s = out_valid && out_ready;
   assign pop_s       = beat_fire_s && last_s;

   // Next-state for pointers, occupancy and the replay position.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      cur_pid_d = cur_pid_q;
      if (push_s) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (beat_fire_s) begin
         cur_pid_d = last_s ? '0 : next_s;
      end else begin
         cur_pid_d = cur_pid_q;
      end
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         cur_pid_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         cur_pid_q <= cur_pid_d;
      end
   end

   // Packet storage; contents are only meaningful while counted as occupied.
   always_ff @(posedge clk) begin
      if (push_s) begin
         meta_mem_q[wr_ptr_q]  <= in_meta;
         tmask_mem_q[wr_ptr_q] <= in_tmask;
         rs1_mem_q[wr_ptr_q]   <= in_rs1;
         rs2_mem_q[wr_ptr_q]   <= in_rs2;
         rs3_mem_q[wr_ptr_q]   <= in_rs3;
      end
   end

endmodule

// File: tb/tb_vx_operands_split.sv
// Directed bench for vx_operands_split: 4-thread skip / no-skip instances and
// an 8-thread instance drained under random backpressure against a beat table.
module tb_vx_operands_split;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 4-thread inputs shared by the skip and no-skip instances
   logic         in_valid, in_valid0;
   logic [63:0]  in_meta;
   logic [3:0]   in_tmask;
   logic [127:0] in_rs1, in_rs2, in_rs3;
   logic         out_ready, out_ready0;

   logic         in_ready, out_valid, out_sop, out_eop, busy;
   logic [63:0]  out_meta;
   logic [1:0]   out_tmask;
   logic [63:0]  out_rs1, out_rs2, out_rs3;
   logic [0:0]   out_pid;

   logic         in_ready0, out_valid0, out_sop0, out_eop0, busy0;
   logic [63:0]  out_meta0;
   logic [1:0]   out_tmask0;
   logic [63:0]  out_rs1_0, out_rs2_0, out_rs3_0;
   logic [0:0]   out_pid0;

   logic         in_valid8, out_ready8, in_ready8, out_valid8, out_sop8, out_eop8, busy8;
   logic [63:0]  in_meta8, out_meta8;
   logic [7:0]   in_tmask8;
   logic [255:0] in_rs1_8;
   logic [1:0]   out_tmask8;
   logic [63:0]  out_rs1_8, out_rs2_8, out_rs3_8;
   logic [1:0]   out_pid8;

   vx_operands_split #(.NUM_THREADS(4), .NUM_LANES(2), .DEPTH(2), .SKIP_EMPTY(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_meta(in_meta), .in_tmask(in_tmask),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_ready(in_ready),
      .out_valid(out_valid), .out_meta(out_meta), .out_tmask(out_tmask),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3), .out_pid(out_pid),
      .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready), .busy(busy));

   vx_operands_split #(.NUM_THREADS(4), .NUM_LANES(2), .DEPTH(2), .SKIP_EMPTY(0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid0), .in_meta(in_meta), .in_tmask(in_tmask),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_ready(in_ready0),
      .out_valid(out_valid0), .out_meta(out_meta0), .out_tmask(out_tmask0),
      .out_rs1(out_rs1_0), .out_rs2(out_rs2_0), .out_rs3(out_rs3_0), .out_pid(out_pid0),
      .out_sop(out_sop0), .out_eop(out_eop0), .out_ready(out_ready0), .busy(busy0));

   vx_operands_split #(.NUM_THREADS(8), .NUM_LANES(2), .DEPTH(2), .SKIP_EMPTY(1)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_meta(in_meta8), .in_tmask(in_tmask8),
      .in_rs1(in_rs1_8), .in_rs2(in_rs1_8), .in_rs3(in_rs1_8), .in_ready(in_ready8),
      .out_valid(out_valid8), .out_meta(out_meta8), .out_tmask(out_tmask8),
      .out_rs1(out_rs1_8), .out_rs2(out_rs2_8), .out_rs3(out_rs3_8), .out_pid(out_pid8),
      .out_sop(out_sop8), .out_eop(out_eop8), .out_ready(out_ready8), .busy(busy8));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] lanes4(input logic [31:0] base);
      logic [127:0] r;
      for (int t = 0; t < 4; t++) r[t*32 +: 32] = base + 32'(t * 17);
      return r;
   endfunction

   function automatic logic [255:0] lanes8(input logic [31:0] base);
      logic [255:0] r;
      for (int t = 0; t < 8; t++) r[t*32 +: 32] = base + 32'(t * 17);
      return r;
   endfunction

   task automatic push(input bit sel, input logic [63:0] meta, input logic [3:0] tm,
                       input logic [31:0] base);
      @(posedge clk); #1;
      in_meta  = meta;
      in_tmask = tm;
      in_rs1   = lanes4(base);
      in_rs2   = lanes4(base + 32'h100);
      in_rs3   = lanes4(base + 32'h200);
      if (sel) in_valid0 = 1'b1;
      else     in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_valid0 = 1'b0;
   endtask

   task automatic beat_chk(input string tag, input int pid, input logic [1:0] tm,
                           input logic [31:0] lo, input logic [31:0] hi,
                           input bit sop, input bit eop, input logic [63:0] meta);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_pid"},   64'(out_pid),   64'(pid));
      chk({tag, "_tmask"}, 64'(out_tmask), 64'(tm));
      chk({tag, "_rs1"},   out_rs1, {hi, lo});
      chk({tag, "_rs2"},   out_rs2, {hi + 32'h100, lo + 32'h100});
      chk({tag, "_rs3"},   out_rs3, {hi + 32'h200, lo + 32'h200});
      chk({tag, "_sop"},   64'(out_sop),   64'(sop));
      chk({tag, "_eop"},   64'(out_eop),   64'(eop));
      chk({tag, "_meta"},  out_meta, meta);
   endtask

   task automatic empty_chk(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_busy"},  64'(busy),      64'd0);
   endtask

   int exp_pid [3] = '{0, 2, 3};
   logic [1:0] exp_tm [3] = '{2'b01, 2'b10, 2'b10};
   int pkt, got, p, b, k;
   logic [31:0] base8;

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_valid0 = 1'b0; in_valid8 = 1'b0;
      in_meta = 64'd0; in_tmask = 4'd0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
      in_meta8 = 64'd0; in_tmask8 = 8'd0; in_rs1_8 = '0;
      out_ready = 1'b1; out_ready0 = 1'b1; out_ready8 = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_sop", 64'(out_sop), 64'd0);
      chk("rst_eop", 64'(out_eop), 64'd0);
      chk("rst_pid", 64'(out_pid), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_valid", 64'(out_valid), 64'd0);

      // Full mask, two beats, first beat the cycle after acceptance
      push(1'b0, 64'h1111, 4'b1111, 32'h0);
      @(negedge clk); beat_chk("t1b0", 0, 2'b11, 32'h00, 32'h11, 1'b1, 1'b0, 64'h1111);
      @(negedge clk); beat_chk("t1b1", 1, 2'b11, 32'h22, 32'h33, 1'b0, 1'b1, 64'h1111);
      @(negedge clk); empty_chk("t1_end");

      // Skipped lower chunk, then an all-zero mask
      push(1'b0, 64'h2222, 4'b1100, 32'h40);
      @(negedge clk); beat_chk("t2a", 1, 2'b11, 32'h62, 32'h73, 1'b1, 1'b1, 64'h2222);
      @(negedge clk); empty_chk("t2a_end");
      push(1'b0, 64'h3333, 4'b0000, 32'h80);
      @(negedge clk); beat_chk("t2b", 0, 2'b00, 32'h80, 32'h91, 1'b1, 1'b1, 64'h3333);
      @(negedge clk); empty_chk("t2b_end");

      // No-skip instance emits the empty upper chunk too
      push(1'b1, 64'h4444, 4'b0001, 32'h0);
      @(negedge clk);
      chk("t3b0_valid", 64'(out_valid0), 64'd1);
      chk("t3b0_pid", 64'(out_pid0), 64'd0);
      chk("t3b0_tmask", 64'(out_tmask0), 64'(2'b01));
      chk("t3b0_sop", 64'(out_sop0), 64'd1);
      chk("t3b0_eop", 64'(out_eop0), 64'd0);
      @(negedge clk);
      chk("t3b1_valid", 64'(out_valid0), 64'd1);
      chk("t3b1_pid", 64'(out_pid0), 64'd1);
      chk("t3b1_tmask", 64'(out_tmask0), 64'(2'b00));
      chk("t3b1_sop", 64'(out_sop0), 64'd0);
      chk("t3b1_eop", 64'(out_eop0), 64'd1);
      chk("t3b1_meta", out_meta0, 64'h4444);
      @(negedge clk);
      chk("t3_end_valid", 64'(out_valid0), 64'd0);

      // Backpressure: third packet refused, outputs frozen
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1; in_meta = 64'hA; in_tmask = 4'b1111;
      in_rs1 = lanes4(32'h100); in_rs2 = lanes4(32'h200); in_rs3 = lanes4(32'h300);
      @(posedge clk); #1;
      in_meta = 64'hB;
      in_rs1 = lanes4(32'h200); in_rs2 = lanes4(32'h300); in_rs3 = lanes4(32'h400);
      @(posedge clk); #1;
      in_meta = 64'hC;
      in_rs1 = lanes4(32'h300); in_rs2 = lanes4(32'h400); in_rs3 = lanes4(32'h500);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t4_full_in_ready", 64'(in_ready), 64'd0);
         beat_chk("t4_hold", 0, 2'b11, 32'h100, 32'h111, 1'b1, 1'b0, 64'hA);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk); beat_chk("t4_a0", 0, 2'b11, 32'h100, 32'h111, 1'b1, 1'b0, 64'hA);
      chk("t4_a0_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk); beat_chk("t4_a1", 1, 2'b11, 32'h122, 32'h133, 1'b0, 1'b1, 64'hA);
      chk("t4_a1_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk); beat_chk("t4_b0", 0, 2'b11, 32'h200, 32'h211, 1'b1, 1'b0, 64'hB);
      chk("t4_b0_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk); beat_chk("t4_b1", 1, 2'b11, 32'h222, 32'h233, 1'b0, 1'b1, 64'hB);
      @(negedge clk); empty_chk("t4_end");

      // Reset mid-packet with a second packet buffered
      @(posedge clk); #1;
      out_ready = 1'b0;
      push(1'b0, 64'h5, 4'b1111, 32'h400);
      push(1'b0, 64'h6, 4'b1111, 32'h600);
      out_ready = 1'b1;
      @(negedge clk); beat_chk("t5_p0", 0, 2'b11, 32'h400, 32'h411, 1'b1, 1'b0, 64'h5);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      empty_chk("t5_in_rst");
      chk("t5_in_rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      empty_chk("t5_after_rst");
      chk("t5_after_rst_in_ready", 64'(in_ready), 64'd1);
      push(1'b0, 64'h7, 4'b1111, 32'h500);
      @(negedge clk); beat_chk("t5_r0", 0, 2'b11, 32'h500, 32'h511, 1'b1, 1'b0, 64'h7);
      @(negedge clk); beat_chk("t5_r1", 1, 2'b11, 32'h522, 32'h533, 1'b0, 1'b1, 64'h7);
      @(negedge clk); empty_chk("t5_end");

      // 8-thread sparse mask under random out_ready, against a beat table
      pkt = 0;
      got = 0;
      for (int cyc = 0; cyc < 400 && got < 9; cyc++) begin
         @(posedge clk); #1;
         out_ready8 = 1'($urandom_range(0, 1));
         in_valid8  = (pkt < 3);
         in_meta8   = 64'hC0DE_0000 + 64'(pkt);
         in_tmask8  = 8'b1010_0001;
         in_rs1_8   = lanes8(32'(pkt) * 32'h1000);
         @(negedge clk);
         if (in_valid8 && in_ready8) pkt++;
         if (out_valid8 && out_ready8) begin
            p = got / 3;
            b = got % 3;
            k = exp_pid[b];
            base8 = 32'(p) * 32'h1000;
            chk("t6_pid", 64'(out_pid8), 64'(k));
            chk("t6_tmask", 64'(out_tmask8), 64'(exp_tm[b]));
            chk("t6_sop", 64'(out_sop8), 64'(b == 0));
            chk("t6_eop", 64'(out_eop8), 64'(b == 2));
            chk("t6_meta", out_meta8, 64'hC0DE_0000 + 64'(p));
            chk("t6_rs1", out_rs1_8, {base8 + 32'((2*k+1) * 17), base8 + 32'(2*k*17)});
            got++;
         end
      end
      chk("t6_beat_count", 64'(got), 64'd9);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t6_no_extra", 64'(out_valid8), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
